// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator operand-entry path.
package calc_pkg;

    localparam int unsigned ACC_W_DEF = 14;
    localparam logic [3:0]  BCD_MAX   = 4'd9;

    typedef enum logic {
        ENTRY,
        CONV
    } state_e;

    // Conversion step order: thousands, hundreds, tens, units.
    localparam logic [1:0] STEP_K = 2'd0;
    localparam logic [1:0] STEP_H = 2'd1;
    localparam logic [1:0] STEP_T = 2'd2;
    localparam logic [1:0] STEP_U = 2'd3;

endpackage

// File: rtl/bcd_weight_scaler.sv
// Combinational shift-add scaler: digit times 1000, 100, 10 or 1 selected by the step code.
module bcd_weight_scaler
    import calc_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic [3:0]       digit,
    input  logic [1:0]       sel,
    output logic [ACC_W-1:0] term
);

    logic [ACC_W-1:0] d;

    assign d = ACC_W'(digit);

    always_comb begin
        term = '0;
        unique case (sel)
            STEP_K:  term = (d << 10) - (d << 4) - (d << 3);
            STEP_H:  term = (d << 6) + (d << 5) + (d << 2);
            STEP_T:  term = (d << 3) + (d << 1);
            STEP_U:  term = d;
            default: term = '0;
        endcase
    end

endmodule

// File: rtl/bcd_operand_loader.sv
// Keypad operand entry: buffers up to four BCD digits and converts them to binary,
// one weighted term per clock through a single shared scaler.
module bcd_operand_loader
    import calc_pkg::*;
#(
    parameter int unsigned ACC_W      = ACC_W_DEF,
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             digit_valid,
    input  logic [3:0]       digit,
    input  logic             enter,
    input  logic             clear,
    output logic             busy,
    output logic [2:0]       digit_count,
    output logic [ACC_W-1:0] value,
    output logic             value_valid,
    output logic             digit_err
);

    if (NUM_DIGITS != 4) begin : g_bad_depth
        $error("bcd_operand_loader: only NUM_DIGITS=4 is supported");
    end
    if (ACC_W < 14) begin : g_bad_width
        $error("bcd_operand_loader: ACC_W must be at least 14");
    end

    state_e           state_q, state_d;
    logic [1:0]       step_q, step_d;
    logic [15:0]      buf_q, buf_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] value_q, value_d;
    logic             vv_q, vv_d;

    logic [3:0]       sel_digit;
    logic [ACC_W-1:0] term;

    // d3 sits in the top nibble, d0 (last keyed) in the bottom.
    always_comb begin
        sel_digit = 4'd0;
        unique case (step_q)
            STEP_K:  sel_digit = buf_q[15:12];
            STEP_H:  sel_digit = buf_q[11:8];
            STEP_T:  sel_digit = buf_q[7:4];
            STEP_U:  sel_digit = buf_q[3:0];
            default: sel_digit = 4'd0;
        endcase
    end

    bcd_weight_scaler #(
        .ACC_W(ACC_W)
    ) u_scaler (
        .digit(sel_digit),
        .sel  (step_q),
        .term (term)
    );

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        acc_d   = acc_q;
        value_d = value_q;
        vv_d    = 1'b0;

        unique case (state_q)
            ENTRY: begin
                if (clear) begin
                    buf_d = '0;
                    cnt_d = '0;
                    err_d = 1'b0;
                end else if (enter) begin
                    state_d = CONV;
                    step_d  = STEP_K;
                    acc_d   = '0;
                end else if (digit_valid) begin
                    if (digit > BCD_MAX || cnt_q == 3'(NUM_DIGITS)) begin
                        err_d = 1'b1;
                    end else begin
                        buf_d = {buf_q[11:0], digit};
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            CONV: begin
                if (clear) begin
                    // Abort: value keeps its previous content, no pulse.
                    state_d = ENTRY;
                    step_d  = STEP_K;
                    buf_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    acc_d   = '0;
                end else begin
                    acc_d  = acc_q + term;
                    step_d = step_q + 2'd1;
                    if (step_q == STEP_U) begin
                        state_d = ENTRY;
                        value_d = acc_q + term;
                        vv_d    = 1'b1;
                        buf_d   = '0;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                    end
                end
            end
            default: state_d = ENTRY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ENTRY;
            step_q  <= STEP_K;
            buf_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            acc_q   <= '0;
            value_q <= '0;
            vv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            acc_q   <= acc_d;
            value_q <= value_d;
            vv_q    <= vv_d;
        end
    end

    assign busy        = (state_q == CONV);
    assign digit_count = cnt_q;
    assign value       = value_q;
    assign value_valid = vv_q;
    assign digit_err   = err_q;

endmodule

// File: tb/tb_bcd_operand_loader.sv
// Directed bench for bcd_operand_loader with a queue of expected operands.
module tb_bcd_operand_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        digit_valid = 1'b0;
    logic [3:0]  digit = 4'd0;
    logic        enter = 1'b0;
    logic        clear = 1'b0;
    logic        busy;
    logic [2:0]  digit_count;
    logic [13:0] value;
    logic        value_valid;
    logic        digit_err;

    int total = 0;
    int bad   = 0;
    int unsigned exp_q[$];

    always #5 clk = ~clk;

    bcd_operand_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digit_valid(digit_valid),
        .digit      (digit),
        .enter      (enter),
        .clear      (clear),
        .busy       (busy),
        .digit_count(digit_count),
        .value      (value),
        .value_valid(value_valid),
        .digit_err  (digit_err)
    );

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are read there too.
    task automatic press(input logic [3:0] d);
        @(negedge clk);
        digit_valid = 1'b1;
        digit       = d;
        @(negedge clk);
        digit_valid = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    // Enter with optional simultaneous digit strobe, then check exact latency and result.
    task automatic convert(input string tag, input int unsigned expv, input logic with_digit);
        int unsigned e;
        @(negedge clk);
        enter = 1'b1;
        if (with_digit) begin
            digit_valid = 1'b1;
            digit       = 4'd7;
        end
        exp_q.push_back(expv);
        @(negedge clk);
        enter       = 1'b0;
        digit_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk({tag, " busy"}, 32'(busy), 1);
            chk({tag, " early_vv"}, 32'(value_valid), 0);
            @(negedge clk);
        end
        chk({tag, " vv"}, 32'(value_valid), 1);
        chk({tag, " busy_end"}, 32'(busy), 0);
        if (value_valid === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, " value"}, 32'(value), e);
        end else begin
            chk({tag, " value_timeout"}, 32'(value_valid), 1);
        end
        chk({tag, " count"}, 32'(digit_count), 0);
        @(negedge clk);
        chk({tag, " vv_pulse"}, 32'(value_valid), 0);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst busy", 32'(busy), 0);
        chk("rst count", 32'(digit_count), 0);
        chk("rst value", 32'(value), 0);
        chk("rst vv", 32'(value_valid), 0);
        chk("rst err", 32'(digit_err), 0);
        @(negedge clk);
        rst_n = 1'b1;

        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        chk("cnt4", 32'(digit_count), 4);
        convert("1234", 1234, 1'b0);

        press(4'd9); press(4'd9); press(4'd9); press(4'd9);
        convert("9999", 9999, 1'b0);

        press(4'd4); press(4'd2);
        chk("cnt2", 32'(digit_count), 2);
        convert("42", 42, 1'b0);

        convert("empty", 0, 1'b0);

        // Excess digit
        press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
        chk("excess cnt", 32'(digit_count), 4);
        chk("excess err", 32'(digit_err), 1);
        convert("excess", 1234, 1'b0);
        chk("err cleared", 32'(digit_err), 0);

        // Illegal digit
        press(4'hC);
        chk("illegal cnt", 32'(digit_count), 0);
        chk("illegal err", 32'(digit_err), 1);
        do_clear();
        chk("clear err", 32'(digit_err), 0);

        // enter wins over a same-cycle digit
        press(4'd5); press(4'd6);
        convert("56", 56, 1'b1);
        chk("56 err", 32'(digit_err), 0);

        // clear during step2
        press(4'd8); press(4'd8);
        @(negedge clk);
        enter = 1'b1;
        @(negedge clk);
        enter = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort busy_pre", 32'(busy), 1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("abort busy", 32'(busy), 0);
        chk("abort count", 32'(digit_count), 0);
        for (int i = 0; i < 5; i++) begin
            chk("abort vv", 32'(value_valid), 0);
            @(negedge clk);
        end
        chk("abort value", 32'(value), 56);

        // Reset during step1
        press(4'd9); press(4'd9);
        @(negedge clk);
        enter = 1'b1;
        @(negedge clk);
        enter = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst busy", 32'(busy), 0);
        chk("mrst value", 32'(value), 0);
        chk("mrst count", 32'(digit_count), 0);
        chk("mrst err", 32'(digit_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("mrst vv", 32'(value_valid), 0);
            @(negedge clk);
        end
        press(4'd3); press(4'd0); press(4'd0); press(4'd0);
        convert("3000", 3000, 1'b0);
        chk("queue empty", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bcd_operand_loader.md
Name: bcd_operand_loader

Overview:
Calculator operand-entry controller. It collects up to 4 BCD keypad digits, most-significant first, and converts them to a 14-bit binary operand. Conversion is time-multiplexed through one shared shift-add weight scaler (x1000, x100, x10, x1): one weighted term is accumulated per clock. It sits between the keypad decoder and the ALU operand registers.

Parameters:
ACC_W, 14, accumulator/result width; must be >= 14 (9999 max).
NUM_DIGITS, 4, digit buffer depth; only 4 is supported; other values are an elaboration error.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
digit_valid  input  1  one-cycle strobe: digit is a new keypress
digit  input  4  BCD digit, legal 0..9
enter  input  1  one-cycle strobe: start conversion of buffered digits
clear  input  1  one-cycle strobe: discard digits / abort conversion
busy  output  1  high while converting
digit_count  output  3  number of buffered digits, 0..4
value  output  ACC_W  last converted operand
value_valid  output  1  one-cycle pulse when value updates
digit_err  output  1  sticky: illegal or excess digit was dropped

Behaviour:
- Reset (async, rst_n=0): state=ENTRY; buffer=0; digit_count=0; acc=0; value=0; value_valid=0; busy=0; digit_err=0. All registers are cleared immediately, including mid-conversion. No value_valid is produced for an interrupted conversion.
- States: ENTRY, CONV (2-bit step 0..3).
- ENTRY, priority per cycle: clear > enter > digit_valid.
  - clear: buffer=0, digit_count=0, digit_err=0.
  - enter: go to CONV with step=0 and acc=0. busy=1 from the next cycle. A digit_valid in the same cycle is dropped; digit_err is not set.
  - digit_valid with digit<=9 and digit_count<4: shift into the buffer (d3<=d2, d2<=d1, d1<=d0, d0<=digit); digit_count+1.
  - digit_valid with digit>9: dropped; digit_err=1.
  - digit_valid with digit_count==4: dropped; digit_err=1.
- Digit alignment: the buffer is right-aligned. With N digits entered, d0 is the last digit and unfilled upper positions are 0. So "1","2" gives d1=1, d0=2, result 12.
- CONV: the step selects the digit and weight: step0 d3x1000, step1 d2x100, step2 d1x10, step3 d0x1. acc <= acc + scaled term.
  - At step3: value <= acc + term; value_valid=1 for exactly one cycle; buffer, digit_count and digit_err cleared; return to ENTRY.
- Latency: if enter is sampled at edge N, value_valid is high in the cycle following edge N+4, i.e. after 4 clocks. busy is high for exactly 4 cycles.
- During CONV, digit_valid and enter are ignored without setting digit_err. clear aborts: return to ENTRY, buffer and acc cleared, no value_valid, value keeps its old content.
- enter with digit_count==0 converts to value=0 with a normal value_valid pulse.
- Arithmetic:
  - Terms are zero-extended to ACC_W before adding.
  - x1000 is computed as (d<<10)-(d<<4)-(d<<3).
  - Max sum 9999 < 2^14, so there is no overflow and no wrap handling.
- value holds until the next completed conversion or reset.

Decomposition:
- Shared package calc_pkg:
  - ACC_W default
  - state enum {ENTRY, CONV}
  - step encoding constants STEP_K, STEP_H, STEP_T, STEP_U
  - BCD_MAX=9
- Sub-module bcd_weight_scaler: combinational. Inputs are a 4-bit digit and a 2-bit weight select; output is an ACC_W product built by shift-add/sub. It is the single shared multiplier instance.
- The controller holds the FSM, buffer, accumulator and flags.

Test Plan:
- Reset, then digits 1,2,3,4, then enter -> busy high for 4 cycles; value_valid after 4 clocks; value=1234; digit_count=0.
- Digits 9,9,9,9, then enter -> value=9999 (0x270F); digit 4,2 then enter -> value=42; enter with no digits -> value=0 with value_valid pulse.
- Digits 1,2,3,4,5 -> digit_count stays 4; digit_err=1; enter -> value=1234 and digit_err cleared. Digit 0xC -> dropped, digit_err=1.
- enter and digit_valid(7) in the same cycle after digits 5,6 -> value=56; the 7 is dropped silently.
- Digits 8,8, enter, clear at CONV step2 -> no value_valid; value unchanged (previous 56); digit_count=0; busy low the next cycle.
- rst_n low for one cycle at CONV step1 -> all outputs 0 immediately; no value_valid; a subsequent 3,0,0,0 + enter gives 3000.
